// File: rtl/iob_cache_fe_arbiter.sv
// Round-robin arbiter that shares one IOb cache front-end port among N_MASTERS requesters.
// Only one transaction is in flight at a time. The requester just served drops to lowest priority.
module iob_cache_fe_arbiter #(
  parameter  int N_MASTERS = 2,
  parameter  int ADDR_W    = 30,
  parameter  int DATA_W    = 32,
  localparam int GRANT_W   = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1,
  localparam int STRB_W    = DATA_W / 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS-1:0]          m_req,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
  input  logic [N_MASTERS*STRB_W-1:0]   m_wstrb,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [N_MASTERS-1:0]          m_ack,
  output logic                          s_req,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  output logic [STRB_W-1:0]             s_wstrb,
  input  logic [DATA_W-1:0]             s_rdata,
  input  logic                          s_ack,
  output logic [GRANT_W-1:0]            grant,
  output logic                          busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             r_state, w_state_nxt;
  logic [GRANT_W-1:0] r_grant, w_grant_nxt;
  logic [GRANT_W-1:0] r_ptr, w_ptr_nxt;
  logic [GRANT_W-1:0] w_sel;

  // Scan from ptr upward and wrap. Iterating downward lets the nearest requester win.
  always_comb begin
    logic [GRANT_W:0] v_idx;
    w_sel = r_ptr;
    v_idx = '0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      v_idx = {1'b0, r_ptr} + (GRANT_W + 1)'(k);
      if (v_idx >= (GRANT_W + 1)'(N_MASTERS)) begin
        v_idx = v_idx - (GRANT_W + 1)'(N_MASTERS);
      end
      if (m_req[v_idx[GRANT_W-1:0]]) begin
        w_sel = v_idx[GRANT_W-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    m_ack       = '0;
    case (r_state)
      IDLE: begin
        if (|m_req) begin
          w_grant_nxt = w_sel;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (s_ack) begin
          m_ack[r_grant] = 1'b1;
          w_state_nxt    = IDLE;
          w_ptr_nxt      = (r_grant == GRANT_W'(N_MASTERS - 1)) ? '0 : r_grant + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // The mux follows grant in both states. Strobes are masked while idle so no write can leak.
  assign s_req   = (r_state == BUSY);
  assign busy    = (r_state == BUSY);
  assign grant   = r_grant;
  assign m_rdata = s_rdata;
  assign s_addr  = m_addr[int'(r_grant)*ADDR_W +: ADDR_W];
  assign s_wdata = m_wdata[int'(r_grant)*DATA_W +: DATA_W];
  assign s_wstrb = (r_state == BUSY) ? m_wstrb[int'(r_grant)*STRB_W +: STRB_W] : '0;

endmodule

// File: tb/tb_iob_cache_fe_arbiter.sv
// Scoreboard bench: stimulus queues expected completions, and monitors compare them on every m_ack.
`timescale 1ns/1ps
module tb_iob_cache_fe_arbiter;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Two-requester instance
  logic [1:0]  m_req2;
  logic [59:0] m_addr2;
  logic [63:0] m_wdata2;
  logic [7:0]  m_wstrb2;
  logic [31:0] m_rdata2;
  logic [1:0]  m_ack2;
  logic        s_req2;
  logic [29:0] s_addr2;
  logic [31:0] s_wdata2;
  logic [3:0]  s_wstrb2;
  logic [31:0] s_rdata2;
  logic        s_ack2;
  logic [0:0]  grant2;
  logic        busy2;

  // Three-requester instance
  logic [2:0]  m_req3;
  logic [89:0] m_addr3;
  logic [95:0] m_wdata3;
  logic [11:0] m_wstrb3;
  logic [31:0] m_rdata3;
  logic [2:0]  m_ack3;
  logic        s_req3;
  logic [29:0] s_addr3;
  logic [31:0] s_wdata3;
  logic [3:0]  s_wstrb3;
  logic [31:0] s_rdata3;
  logic        s_ack3;
  logic [1:0]  grant3;
  logic        busy3;

  iob_cache_fe_arbiter #(.N_MASTERS(2), .ADDR_W(30), .DATA_W(32)) dut2 (
    .clk(clk), .rst(rst), .m_req(m_req2), .m_addr(m_addr2), .m_wdata(m_wdata2),
    .m_wstrb(m_wstrb2), .m_rdata(m_rdata2), .m_ack(m_ack2), .s_req(s_req2),
    .s_addr(s_addr2), .s_wdata(s_wdata2), .s_wstrb(s_wstrb2), .s_rdata(s_rdata2),
    .s_ack(s_ack2), .grant(grant2), .busy(busy2)
  );

  iob_cache_fe_arbiter #(.N_MASTERS(3), .ADDR_W(30), .DATA_W(32)) dut3 (
    .clk(clk), .rst(rst), .m_req(m_req3), .m_addr(m_addr3), .m_wdata(m_wdata3),
    .m_wstrb(m_wstrb3), .m_rdata(m_rdata3), .m_ack(m_ack3), .s_req(s_req3),
    .s_addr(s_addr3), .s_wdata(s_wdata3), .s_wstrb(s_wstrb3), .s_rdata(s_rdata3),
    .s_ack(s_ack3), .grant(grant3), .busy(busy3)
  );

  exp_t q2[$];
  exp_t q3[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_ack(input string tag, input exp_t e, input logic [7:0] ack,
                           input logic [7:0] gnt, input logic [31:0] rd, input logic [29:0] ad,
                           input logic [31:0] wd, input logic [3:0] ws);
    chk({tag, "_ack_onehot"}, 64'(ack), 64'(8'd1 << e.idx));
    chk({tag, "_grant"},      64'(gnt), 64'(e.idx));
    chk({tag, "_rdata"},      64'(rd),  64'(e.rdata));
    chk({tag, "_addr"},       64'(ad),  64'(e.addr));
    chk({tag, "_wdata"},      64'(wd),  64'(e.wdata));
    chk({tag, "_wstrb"},      64'(ws),  64'(e.wstrb));
  endtask

  // Cache models: ack after lat cycles of s_req, or on a forced spurious pulse.
  int          lat2 = 3, cnt2 = 0, lat3 = 1, cnt3 = 0;
  logic        spur2 = 1'b0;
  logic [31:0] rdata2 = '0, rdata3 = '0;

  initial begin
    s_ack2 = 1'b0; s_rdata2 = '0;
    forever begin
      @(posedge clk); #1;
      s_ack2 = spur2;
      if (rst || !s_req2) cnt2 = 0;
      else begin
        cnt2++;
        if (cnt2 >= lat2) begin s_ack2 = 1'b1; s_rdata2 = rdata2; cnt2 = 0; end
      end
    end
  end

  initial begin
    s_ack3 = 1'b0; s_rdata3 = '0;
    forever begin
      @(posedge clk); #1;
      s_ack3 = 1'b0;
      if (rst || !s_req3) cnt3 = 0;
      else begin
        cnt3++;
        if (cnt3 >= lat3) begin s_ack3 = 1'b1; s_rdata3 = rdata3; cnt3 = 0; end
      end
    end
  end

  // Monitors
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (m_ack2 != '0) begin
      if (q2.size() == 0) chk("ack2_unexpected", 64'(m_ack2), 64'd0);
      else begin
        e = q2.pop_front();
        check_ack("dut2", e, 8'(m_ack2), 8'(grant2), m_rdata2, s_addr2, s_wdata2, s_wstrb2);
      end
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (m_ack3 != '0) begin
      if (q3.size() == 0) chk("ack3_unexpected", 64'(m_ack3), 64'd0);
      else begin
        e = q3.pop_front();
        check_ack("dut3", e, 8'(m_ack3), 8'(grant3), m_rdata3, s_addr3, s_wdata3, s_wstrb3);
      end
    end
  end

  task automatic go2(input logic [1:0] req);
    @(posedge clk); #1;
    m_req2 = req;
  endtask

  task automatic go3(input logic [2:0] req);
    @(posedge clk); #1;
    m_req3 = req;
  endtask

  task automatic wait_acks2(input int n, input string nm);
    int seen = 0;
    int cyc = 0;
    while (seen < n && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (m_ack2 != '0) seen++;
    end
    chk(nm, 64'(seen), 64'(n));
  endtask

  task automatic wait_acks3(input int n, input string nm);
    int seen = 0;
    int cyc = 0;
    while (seen < n && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (m_ack3 != '0) seen++;
    end
    chk(nm, 64'(seen), 64'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    m_req2 = '0; m_addr2 = '0; m_wdata2 = '0; m_wstrb2 = '0;
    m_req3 = '0; m_addr3 = '0; m_wdata3 = '0; m_wstrb3 = '0;
    #2;
    chk("rst_sreq", 64'(s_req2), 64'd0);
    chk("rst_busy", 64'(busy2), 64'd0);
    chk("rst_mack", 64'(m_ack2), 64'd0);
    chk("rst_grant", 64'(grant2), 64'd0);
    chk("rst_sreq3", 64'(s_req3), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single read from requester 0
    m_addr2[0 +: 30] = 30'h100;
    rdata2 = 32'hDEADBEEF;
    q2.push_back('{0, 32'hDEADBEEF, 30'h100, 32'h0, 4'h0});
    go2(2'b01);
    @(negedge clk); chk("t1_sreq_first_cycle", 64'(s_req2), 64'd0);
    @(negedge clk); chk("t1_sreq_latency", 64'(s_req2), 64'd1);
    chk("t1_busy", 64'(busy2), 64'd1);
    wait_acks2(1, "t1_acks");
    go2(2'b00);
    @(negedge clk); chk("t1_sreq_after_ack", 64'(s_req2), 64'd0);

    // Write from requester 1
    m_addr2[30 +: 30] = 30'h40;
    m_wdata2[32 +: 32] = 32'h12345678;
    m_wstrb2[4 +: 4] = 4'hF;
    rdata2 = 32'h0BADF00D;
    q2.push_back('{1, 32'h0BADF00D, 30'h40, 32'h12345678, 4'hF});
    go2(2'b10);
    wait_acks2(1, "t2_acks");
    go2(2'b00);
    @(negedge clk); chk("t2_idle_wstrb_forced", 64'(s_wstrb2), 64'd0);
    chk("t2_grant_held", 64'(grant2), 64'd1);

    // Contention: both held, grants alternate starting from 0
    m_wstrb2[4 +: 4] = 4'h0;
    m_wdata2[32 +: 32] = 32'h0;
    m_addr2[0 +: 30] = 30'h200;
    m_addr2[30 +: 30] = 30'h300;
    rdata2 = 32'hC0FFEE00;
    q2.push_back('{0, 32'hC0FFEE00, 30'h200, 32'h0, 4'h0});
    q2.push_back('{1, 32'hC0FFEE00, 30'h300, 32'h0, 4'h0});
    q2.push_back('{0, 32'hC0FFEE00, 30'h200, 32'h0, 4'h0});
    q2.push_back('{1, 32'hC0FFEE00, 30'h300, 32'h0, 4'h0});
    go2(2'b11);
    wait_acks2(4, "t3_acks");
    go2(2'b00);

    // Requester drops m_req before ack; ack still arrives
    m_addr2[0 +: 30] = 30'h280;
    rdata2 = 32'h11112222;
    q2.push_back('{0, 32'h11112222, 30'h280, 32'h0, 4'h0});
    go2(2'b01);
    @(negedge clk);
    @(negedge clk); chk("t4_sreq", 64'(s_req2), 64'd1);
    go2(2'b00);
    wait_acks2(1, "t4_acks");

    // Spurious ack while idle
    @(negedge clk); spur2 = 1'b1;
    @(negedge clk);
    chk("t5_mack", 64'(m_ack2), 64'd0);
    chk("t5_busy", 64'(busy2), 64'd0);
    spur2 = 1'b0;
    @(negedge clk);
    chk("t5_sreq", 64'(s_req2), 64'd0);
    chk("t5_grant", 64'(grant2), 64'd0);

    // Reset mid-transaction: ptr is 1 so requester 1 is granted, then reset restarts from 0
    rdata2 = 32'h5A5A5A5A;
    go2(2'b11);
    @(negedge clk);
    @(negedge clk);
    chk("t6_sreq_before_rst", 64'(s_req2), 64'd1);
    chk("t6_grant_before_rst", 64'(grant2), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_sreq", 64'(s_req2), 64'd0);
    chk("t6_rst_busy", 64'(busy2), 64'd0);
    chk("t6_rst_mack", 64'(m_ack2), 64'd0);
    @(posedge clk); #1;
    q2.push_back('{0, 32'h5A5A5A5A, 30'h280, 32'h0, 4'h0});
    rst = 1'b0;
    wait_acks2(1, "t6_acks");
    go2(2'b00);

    // Three requesters: grants 0,1,2,0 with wrap
    m_addr3[0 +: 30] = 30'h10;
    m_addr3[30 +: 30] = 30'h20;
    m_addr3[60 +: 30] = 30'h30;
    rdata3 = 32'h33330000;
    q3.push_back('{0, 32'h33330000, 30'h10, 32'h0, 4'h0});
    q3.push_back('{1, 32'h33330000, 30'h20, 32'h0, 4'h0});
    q3.push_back('{2, 32'h33330000, 30'h30, 32'h0, 4'h0});
    q3.push_back('{0, 32'h33330000, 30'h10, 32'h0, 4'h0});
    go3(3'b111);
    wait_acks3(4, "t7_acks");
    go3(3'b000);

    repeat (3) @(negedge clk);
    chk("q2_drained", 64'(q2.size()), 64'd0);
    chk("q3_drained", 64'(q3.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/iob_cache_fe_arbiter.md
Name: iob_cache_fe_arbiter

Overview:
- Round-robin arbiter sharing one IOb-native cache front-end port (req/addr/wdata/wstrb/rdata/ack) between N_MASTERS requesters, e.g. CPU instruction and data ports feeding one iob_cache_axi instance.
- One transaction is outstanding at a time.
- Priority rotates after every completed transaction so no requester starves.

Parameters:
- N_MASTERS, 2, number of requesters (2..8).
- ADDR_W, 30, width of one requester's address field (word address plus any control bit); passed through unchanged.
- DATA_W, 32, data width.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- m_req  input  N_MASTERS  per-requester request; bit i is requester i.
- m_addr  input  N_MASTERS*ADDR_W  flattened addresses; requester i occupies [i*ADDR_W +: ADDR_W].
- m_wdata  input  N_MASTERS*DATA_W  flattened write data.
- m_wstrb  input  N_MASTERS*DATA_W/8  flattened byte strobes; all-zero means read.
- m_rdata  output  DATA_W  read data, broadcast to all requesters; valid only with that requester's m_ack bit.
- m_ack  output  N_MASTERS  one-hot completion pulse.
- s_req  output  1  request to cache front-end.
- s_addr  output  ADDR_W  muxed address.
- s_wdata  output  DATA_W  muxed write data.
- s_wstrb  output  DATA_W/8  muxed strobes.
- s_rdata  input  DATA_W  cache read data.
- s_ack  input  1  cache completion pulse.
- grant  output  clog2(N_MASTERS)  index of the current or last granted requester.
- busy  output  1  high while a transaction is outstanding.

Behaviour:
- Reset (async, rst=1) values:
  - state IDLE; s_req=0, busy=0, m_ack=0, grant=0.
  - Priority pointer ptr=0, so requester 0 has highest priority first.
- Requester protocol: hold m_req[i] high with stable addr/wdata/wstrb until m_ack[i] pulses. m_req[i] may be high again in the cycle after ack.

State machine (registered):
- IDLE:
  - If |m_req, select the first requester with m_req set, searching i = ptr, ptr+1, … modulo N_MASTERS.
  - Register grant ← i and go to BUSY.
  - s_req stays 0 in this cycle.
- BUSY:
  - s_req=1 and busy=1, both driven from registered state.
  - s_addr/s_wdata/s_wstrb are a combinational mux of the granted requester's fields.
  - On s_ack=1: m_ack[grant]=1 in the same cycle (combinational) and m_rdata=s_rdata. Next state is IDLE and ptr ← (grant+1) mod N_MASTERS, with wrap from N_MASTERS-1 to 0.
  - s_req is low in the cycle after s_ack, so the cache never sees a spurious back-to-back request.

Outputs and latency:
- In IDLE: s_addr/s_wdata/s_wstrb show grant's fields; s_wstrb is forced to 0.
- m_ack is 0 whenever s_ack=0 or state=IDLE.
- Latency from m_req to s_req is 1 cycle. A requester waits at least 1 + cache latency cycles.
- With continuous contention, one transaction completes per (cache latency + 2) cycles.

Boundary cases:
- Granted requester drops m_req before ack (protocol violation): s_req is held until s_ack, and m_ack still pulses.
- s_ack while IDLE: ignored. No m_ack, no state change.
- Simultaneous requests: resolved strictly by ptr order. The requester just served becomes lowest priority.
- New m_req arriving during BUSY: queued implicitly via the held m_req and arbitrated in the next IDLE cycle.
- Reset mid-transaction: abort to IDLE, drop s_req, discard any pending s_ack, ptr returns to 0.
- N_MASTERS=1: degenerates to a pass-through with 1-cycle request latency; grant is 1 bit and stays 0.

Test Plan:
- Reset, single read: m_req=01, m_addr[0]=0x100, s_ack asserted 2 cycles after s_req with s_rdata=0xDEADBEEF -> s_req rises 1 cycle after m_req; s_addr=0x100, s_wstrb=0; m_ack=01 with m_rdata=0xDEADBEEF; s_req=0 the next cycle.
- Simultaneous requests: m_req=11 held, cache acks every request -> grants in order 0,1,0,1; each m_ack one-hot; ptr alternates.
- Write passthrough: requester 1 writes wdata=0x12345678, wstrb=0xF at addr 0x40 -> s_wdata=0x12345678, s_wstrb=0xF, s_addr=0x40, grant=1; m_ack=10.
- Wrap-around with N_MASTERS=3: all requesting, start ptr=0 -> grants 0,1,2,0; ptr wraps 2→0.
- Spurious ack: s_ack=1 while IDLE -> m_ack=0, busy=0, no state change.
- Async reset mid-BUSY: rst pulsed while s_req=1 -> s_req=0, busy=0, m_ack=0 immediately; next arbitration starts from requester 0.
